// File: rtl/psk_frame_ctrl.sv
// ---------------------------------------------------------------------------
// psk_frame_ctrl
//
// Purpose:
//   Frames the hard decisions coming out of the PSK symbol detector. It hunts
//   for a sync word, reads a one-byte length header, and packs the payload
//   bits MSB-first into bytes. The bytes leave on an AXI-Stream-style port,
//   with tlast marking the final byte of each frame.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   enable      run control; low forces IDLE on the next clock
//   mode        0 = BPSK, 1 = QPSK; latched only when leaving IDLE
//   sym_vld     one-cycle strobe marking a new decision
//   bpsk_bit    BPSK decision bit
//   qpsk_dibit  QPSK decision; bit1 = I (enters first), bit0 = Q
//   m_tdata     payload byte
//   m_tvalid    payload byte valid
//   m_tready    sink ready
//   m_tlast     last byte of the frame
//   locked      high while in HEADER or PAYLOAD
//   frame_cnt   completed frames, wraps modulo 2^CNT_W
//   ovf         sticky overrun flag, cleared on entry to IDLE
//   len_err     one-cycle pulse when a zero-length header is received
// ---------------------------------------------------------------------------
module psk_frame_ctrl #(
   parameter logic [31:0] SYNC_WORD = 32'h1ACFFC1D,
   parameter int          SYNC_LEN  = 32,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             mode,
   input  logic             sym_vld,
   input  logic             bpsk_bit,
   input  logic [1:0]       qpsk_dibit,
   output logic [7:0]       m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   output logic             locked,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             ovf,
   output logic             len_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HUNT    = 2'd1,
      HEADER  = 2'd2,
      PAYLOAD = 2'd3
   } state_t;

   localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];

   state_t              state;
   logic                mode_q;
   logic [SYNC_LEN-1:0] hunt_sr;
   logic [7:0]          pack_sr;
   logic [3:0]          bit_cnt;
   logic [7:0]          len_q;
   logic [7:0]          byte_idx;

   logic [SYNC_LEN-1:0] hunt_next;
   logic [7:0]          pack_next;
   logic [3:0]          bit_cnt_next;
   logic                byte_done;
   logic                sync_hit;
   logic                last_byte;
   logic                out_free;

   // The next value of each shift register once the current symbol has been
   // inserted. In QPSK the whole dibit goes in at once with I above Q, so I
   // is the earlier bit in the MSB-first stream. The header and the payload
   // bytes share one packer, because they never overlap in time.
   assign hunt_next    = mode_q ? {hunt_sr[SYNC_LEN-3:0], qpsk_dibit}
                                : {hunt_sr[SYNC_LEN-2:0], bpsk_bit};
   assign pack_next    = mode_q ? {pack_sr[5:0], qpsk_dibit}
                                : {pack_sr[6:0], bpsk_bit};
   assign bit_cnt_next = bit_cnt + (mode_q ? 4'd2 : 4'd1);

   // SYNC_LEN and 8 are both even, so a QPSK symbol never straddles the end
   // of the sync word, the header or a byte. A simple "reached 8" test is
   // therefore enough to detect a completed byte.
   assign byte_done = (bit_cnt_next == 4'd8);
   assign sync_hit  = (hunt_next == SYNC_PAT);
   assign last_byte = (byte_idx == (len_q - 8'd1));

   // The output register can take a new byte when it is empty, or when the
   // byte it holds is being accepted on this very edge.
   assign out_free = !m_tvalid || m_tready;

   // Main sequencer. The state, the packers and all registered outputs live
   // in this one block. The output handshake is evaluated first and does not
   // depend on the state, so a pending byte is still delivered after an
   // enable drop. Loading a freshly completed byte later in the block
   // overrides the handshake clear. Dropping enable takes priority over
   // everything else, and the partial frame is discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mode_q    <= 1'b0;
         hunt_sr   <= '0;
         pack_sr   <= '0;
         bit_cnt   <= '0;
         len_q     <= '0;
         byte_idx  <= '0;
         m_tdata   <= '0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         locked    <= 1'b0;
         frame_cnt <= '0;
         ovf       <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         len_err <= 1'b0;

         if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
         end

         if (!enable) begin
            state  <= IDLE;
            locked <= 1'b0;
            ovf    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= HUNT;
                  mode_q   <= mode;
                  hunt_sr  <= '0;
                  pack_sr  <= '0;
                  bit_cnt  <= '0;
                  byte_idx <= '0;
                  ovf      <= 1'b0;
               end

               HUNT: begin
                  if (sym_vld) begin
                     if (sync_hit) begin
                        state   <= HEADER;
                        locked  <= 1'b1;
                        hunt_sr <= '0;
                        pack_sr <= '0;
                        bit_cnt <= '0;
                     end else begin
                        hunt_sr <= hunt_next;
                     end
                  end
               end

               HEADER: begin
                  if (sym_vld) begin
                     if (byte_done) begin
                        pack_sr  <= '0;
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                        if (pack_next == 8'd0) begin
                           len_err <= 1'b1;
                           locked  <= 1'b0;
                           state   <= HUNT;
                        end else begin
                           len_q <= pack_next;
                           state <= PAYLOAD;
                        end
                     end else begin
                        pack_sr <= pack_next;
                        bit_cnt <= bit_cnt_next;
                     end
                  end
               end

               PAYLOAD: begin
                  if (sym_vld) begin
                     if (byte_done) begin
                        pack_sr <= '0;
                        bit_cnt <= '0;
                        if (out_free) begin
                           m_tdata  <= pack_next;
                           m_tlast  <= last_byte;
                           m_tvalid <= 1'b1;
                        end else begin
                           ovf <= 1'b1;
                        end
                        // The frame still closes even if its last byte was
                        // dropped.
                        if (last_byte) begin
                           state     <= HUNT;
                           locked    <= 1'b0;
                           byte_idx  <= '0;
                           frame_cnt <= frame_cnt + CNT_W'(1);
                        end else begin
                           byte_idx <= byte_idx + 8'd1;
                        end
                     end else begin
                        pack_sr <= pack_next;
                        bit_cnt <= bit_cnt_next;
                     end
                  end
               end

               default: begin
                  state  <= IDLE;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_psk_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_psk_frame_ctrl
//
// Purpose:
//   Self-checking bench for psk_frame_ctrl. A table of frame records drives
//   whole frames (sync, header, payload) in BPSK or QPSK and compares the
//   bytes, lock, len_err and frame count against hand-computed values.
//   Hand-written sequences then cover overrun, enable drop and asynchronous
//   reset.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_psk_frame_ctrl;

   localparam logic [31:0] SYNC = 32'h1ACFFC1D;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        mode;
   logic        sym_vld;
   logic        bpsk_bit;
   logic [1:0]  qpsk_dibit;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        locked;
   logic [15:0] frame_cnt;
   logic        ovf;
   logic        len_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        mode;
      logic        restart;
      logic [31:0] sync_word;
      logic        send_hdr;
      logic [7:0]  len;
      logic [31:0] payload;
      logic        exp_lock;
      logic        exp_len_err;
      int          exp_frames;
   } vec_t;

   vec_t vecs[5];
   vec_t extra;

   psk_frame_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .mode       (mode),
      .sym_vld    (sym_vld),
      .bpsk_bit   (bpsk_bit),
      .qpsk_dibit (qpsk_dibit),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .locked     (locked),
      .frame_cnt  (frame_cnt),
      .ovf        (ovf),
      .len_err    (len_err)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, required finish before 500000ns");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
      end
   endtask

   // Move to one time unit after the next rising edge, where the bench both
   // samples and drives.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one symbol for exactly one clock cycle.
   task automatic send_sym(input logic [1:0] s);
      sym_vld    = 1'b1;
      bpsk_bit   = s[0];
      qpsk_dibit = s;
      tick();
      sym_vld    = 1'b0;
   endtask

   // Send the low n bits of 'bits' MSB-first, one or two per symbol.
   task automatic send_bits(input logic [31:0] bits, input int n, input logic md);
      int i;
      i = n - 1;
      while (i >= 0) begin
         if (md) begin
            send_sym({bits[i], bits[i-1]});
            i -= 2;
         end else begin
            send_sym({1'b0, bits[i]});
            i -= 1;
         end
      end
   endtask

   // Send one payload byte. With the sink ready, the output must still be
   // empty before the completing symbol. One cycle after the completing
   // symbol the output register must show the expected byte.
   task automatic send_byte_chk(input string name, input logic [7:0] b,
                                input logic md, input logic [7:0] exp_data,
                                input logic exp_last);
      logic [31:0] head;
      int          bps;
      bps  = md ? 2 : 1;
      head = {24'd0, b} >> bps;
      send_bits(head, 8 - bps, md);
      if (m_tready)
         checkOutput({name, " tvalid before"}, m_tvalid, 1'b0);
      if (md)
         send_sym(b[1:0]);
      else
         send_sym({1'b0, b[0]});
      checkOutput({name, " tvalid"}, m_tvalid, 1'b1);
      checkOutput({name, " tdata"},  m_tdata,  exp_data);
      checkOutput({name, " tlast"},  m_tlast,  exp_last);
   endtask

   // Pass through IDLE so that the new mode is latched and the hunt starts
   // clean.
   task automatic restart_hunt(input logic md);
      enable = 1'b0;
      tick();
      mode   = md;
      enable = 1'b1;
      tick();
   endtask

   // Run one table record: optionally restart, send the sync word, the
   // header and the payload, and compare at every frame milestone.
   task automatic applyStimulus(input int id, input vec_t v);
      logic [31:0] pay;
      logic [7:0]  b;
      pay      = v.payload;
      m_tready = 1'b1;
      if (v.restart)
         restart_hunt(v.mode);
      send_bits(v.sync_word, 32, v.mode);
      checkOutput($sformatf("vec%0d locked after sync", id), locked, v.exp_lock);
      if (v.send_hdr) begin
         send_bits({24'd0, v.len}, 8, v.mode);
         checkOutput($sformatf("vec%0d len_err", id), len_err, v.exp_len_err);
         checkOutput($sformatf("vec%0d locked after header", id), locked, !v.exp_len_err);
         for (int i = 0; i < int'(v.len); i++) begin
            b = pay[31-8*i -: 8];
            send_byte_chk($sformatf("vec%0d byte%0d", id, i), b, v.mode, b,
                          (i == int'(v.len) - 1));
         end
         if (v.len != 8'd0)
            checkOutput($sformatf("vec%0d locked after frame", id), locked, 1'b0);
         tick();
         checkOutput($sformatf("vec%0d tvalid drained", id), m_tvalid, 1'b0);
         checkOutput($sformatf("vec%0d len_err cleared", id), len_err, 1'b0);
      end
      checkOutput($sformatf("vec%0d frame_cnt", id), frame_cnt, v.exp_frames);
   endtask

   initial begin
      int xfers;

      // mode, restart, sync, send_hdr, len, payload, exp_lock, exp_len_err, exp_frames
      vecs[0] = '{1'b0, 1'b1, SYNC,          1'b1, 8'd3, 32'hA53C0F00, 1'b1, 1'b0, 1};
      vecs[1] = '{1'b1, 1'b1, SYNC,          1'b1, 8'd3, 32'hA53C0F00, 1'b1, 1'b0, 2};
      vecs[2] = '{1'b0, 1'b1, 32'h1ACFFC1C,  1'b0, 8'd0, 32'h00000000, 1'b0, 1'b0, 2};
      vecs[3] = '{1'b0, 1'b0, SYNC,          1'b1, 8'd0, 32'h00000000, 1'b1, 1'b1, 2};
      vecs[4] = '{1'b1, 1'b1, SYNC,          1'b1, 8'd1, 32'hC3000000, 1'b1, 1'b0, 3};

      rst        = 1'b1;
      enable     = 1'b0;
      mode       = 1'b0;
      sym_vld    = 1'b0;
      bpsk_bit   = 1'b0;
      qpsk_dibit = 2'b00;
      m_tready   = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state.
      checkOutput("reset tvalid",    m_tvalid,  1'b0);
      checkOutput("reset tdata",     m_tdata,   8'h00);
      checkOutput("reset tlast",     m_tlast,   1'b0);
      checkOutput("reset locked",    locked,    1'b0);
      checkOutput("reset frame_cnt", frame_cnt, 16'd0);
      checkOutput("reset ovf",       ovf,       1'b0);
      checkOutput("reset len_err",   len_err,   1'b0);

      for (int k = 0; k < 5; k++)
         applyStimulus(k, vecs[k]);

      // Overrun: sink stalled across a 2-byte BPSK frame.
      m_tready = 1'b0;
      restart_hunt(1'b0);
      send_bits(SYNC, 32, 1'b0);
      send_bits(32'd2, 8, 1'b0);
      send_byte_chk("ovf byte0", 8'h11, 1'b0, 8'h11, 1'b0);
      checkOutput("ovf before drop", ovf, 1'b0);
      send_byte_chk("ovf byte1 held", 8'h22, 1'b0, 8'h11, 1'b0);
      checkOutput("ovf set",          ovf,       1'b1);
      checkOutput("ovf frame_cnt",    frame_cnt, 16'd4);
      checkOutput("ovf locked",       locked,    1'b0);

      // The pending byte survives an enable drop, and ovf clears on entry to
      // IDLE.
      enable = 1'b0;
      tick();
      checkOutput("idle pending tvalid", m_tvalid, 1'b1);
      checkOutput("idle pending tdata",  m_tdata,  8'h11);
      checkOutput("idle ovf cleared",    ovf,      1'b0);

      // Only the held byte transfers once the sink is ready again.
      m_tready = 1'b1;
      xfers    = 0;
      for (int c = 0; c < 4; c++) begin
         if (m_tvalid && m_tready) begin
            xfers++;
            checkOutput("ovf xfer tdata", m_tdata, 8'h11);
         end
         tick();
      end
      checkOutput("ovf xfer count", xfers, 1);
      checkOutput("ovf tvalid after", m_tvalid, 1'b0);

      // Enable drop after one of four payload bytes.
      restart_hunt(1'b0);
      send_bits(SYNC, 32, 1'b0);
      send_bits(32'd4, 8, 1'b0);
      send_byte_chk("drop byte0", 8'h5A, 1'b0, 8'h5A, 1'b0);
      send_bits(32'h6, 4, 1'b0);
      enable = 1'b0;
      tick();
      checkOutput("drop locked", locked, 1'b0);
      checkOutput("drop tvalid", m_tvalid, 1'b0);
      send_bits(32'hFF, 8, 1'b0);
      checkOutput("drop idle tvalid",    m_tvalid,  1'b0);
      checkOutput("drop idle locked",    locked,    1'b0);
      checkOutput("drop idle frame_cnt", frame_cnt, 16'd4);

      // A clean hunt after re-enable.
      extra = '{1'b0, 1'b1, SYNC, 1'b1, 8'd1, 32'h81000000, 1'b1, 1'b0, 5};
      applyStimulus(5, extra);

      // Asynchronous reset mid-frame with a byte pending.
      m_tready = 1'b0;
      restart_hunt(1'b0);
      send_bits(SYNC, 32, 1'b0);
      send_bits(32'd2, 8, 1'b0);
      send_byte_chk("rst byte0", 8'hE7, 1'b0, 8'hE7, 1'b0);
      send_bits(32'h5, 3, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async rst tvalid",    m_tvalid,  1'b0);
      checkOutput("async rst tdata",     m_tdata,   8'h00);
      checkOutput("async rst tlast",     m_tlast,   1'b0);
      checkOutput("async rst locked",    locked,    1'b0);
      checkOutput("async rst frame_cnt", frame_cnt, 16'd0);
      checkOutput("async rst ovf",       ovf,       1'b0);
      #1;
      rst      = 1'b0;
      m_tready = 1'b1;
      tick();
      checkOutput("post rst tvalid", m_tvalid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/psk_frame_ctrl.md
Name: psk_frame_ctrl

Overview:
- Sequences the PSK symbol-detection datapath into framed byte output.
- Takes per-symbol hard decisions (BPSK bit or QPSK dibit plus a valid strobe), hunts for a sync word, reads a one-byte length header, then packs the payload bits into bytes.
- Payload bytes leave on an AXI-Stream-style byte port with tlast on the final byte.
- Sits between the symbol detector and the byte sink (FIFO or DMA).

Parameters:
- SYNC_WORD, 32'h1ACFFC1D, sync pattern, MSB is received first.
- SYNC_LEN, 32, number of valid LSBs of SYNC_WORD that are compared. Must be even and in the range 8..32.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run control; low forces IDLE
- mode  in  1  0 = BPSK, 1 = QPSK; sampled only on the IDLE->HUNT transition
- sym_vld  in  1  one-cycle strobe marking a new decision
- bpsk_bit  in  1  BPSK decision bit
- qpsk_dibit  in  2  QPSK decision; bit1 is I, bit0 is Q
- m_tdata  out  8  payload byte
- m_tvalid  out  1  byte valid
- m_tready  in  1  sink ready
- m_tlast  out  1  last byte of frame
- locked  out  1  high in HEADER or PAYLOAD
- frame_cnt  out  CNT_W  completed frames; wraps modulo 2^CNT_W
- ovf  out  1  sticky overrun flag
- len_err  out  1  one-cycle pulse on a zero-length header

Behaviour:
- Reset values: state IDLE; m_tdata 0; m_tvalid 0; m_tlast 0; locked 0; frame_cnt 0; ovf 0; len_err 0. All internal shift registers and counters are 0.
- Bit order:
  - BPSK: one bit per sym_vld.
  - QPSK: two bits per sym_vld; I (dibit[1]) enters first, then Q.
  - Bits are shifted in MSB-first into a hunt register, header and byte packers.
- IDLE:
  - All counters are held.
  - ovf clears on entry.
  - enable=1 -> HUNT on the next clk and latches mode.
- HUNT:
  - Each sym_vld shifts the new bit(s) into the SYNC_LEN-bit hunt register.
  - The compare runs after the full symbol has been inserted, so QPSK sync is symbol-aligned only.
  - A match moves to HEADER on the same edge.
  - The hunt register clears on the match.
- HEADER:
  - Collects 8 bits into L.
  - L=0: pulse len_err for one cycle and return to HUNT.
  - L>0: move to PAYLOAD with a byte counter of 0.
- PAYLOAD:
  - Every 8 bits completes a byte.
  - Byte boundaries always coincide with symbol boundaries, because SYNC_LEN and 8 are both even.
  - When byte index L-1 completes: m_tlast=1 with that byte, frame_cnt increments, state -> HUNT.
- Output register:
  - A completed byte loads m_tdata/m_tlast and sets m_tvalid on the clk edge after the completing sym_vld (latency 1 cycle).
  - m_tvalid stays high and m_tdata/m_tlast stay stable until m_tvalid && m_tready.
  - If a byte completes while m_tvalid=1 and m_tready=0: the new byte is dropped and ovf is set.
  - If the dropped byte was the last byte, the FSM still returns to HUNT and frame_cnt still increments.
  - A handshake and a new completion in the same cycle is not an overflow; the new byte loads.
- Control edge cases:
  - sym_vld is ignored in IDLE.
  - enable=0 in any state -> IDLE on the next clk; the partial frame is discarded.
  - A pending output byte survives an enable drop and is held until accepted.
  - mode changes outside IDLE have no effect.
- Reset mid-frame: all state and outputs return to reset values immediately (asynchronous). Any pending byte is lost.

Test Plan:
- BPSK, SYNC 1ACFFC1D, L=3, payload A5 3C 0F, m_tready=1 -> three bytes A5, 3C, 0F; m_tlast only on 0F; frame_cnt=1; locked falls after 0F.
- QPSK, same frame as 2-bit dibits -> identical bytes; each byte appears 1 cycle after its 4th symbol.
- BPSK, 31 sync bits + wrong bit, then a correct sync with L=0 -> no lock on the first attempt; len_err pulse on the second; state back to HUNT; frame_cnt=0.
- m_tready=0 for a 2-byte frame -> first byte held; second dropped; ovf=1; frame_cnt=1. Raise m_tready -> only the first byte transfers.
- enable=0 after 1 of 4 payload bytes -> IDLE; no further bytes; locked=0; ovf cleared. Re-enable -> clean hunt.
- Assert rst with m_tvalid=1 mid-frame -> all outputs 0 without waiting for a clk edge; frame_cnt=0.
